// File: rtl/modo_counter_param_pkg.sv
// Shared mode codes and default geometry for the modo counter family.
// The RTL and the testbench both import this package.
package modo_counter_param_pkg;

    typedef enum logic [1:0] {
        MODO_UP_STEP = 2'b00,
        MODO_DOWN    = 2'b01,
        MODO_UP      = 2'b10,
        MODO_LOAD    = 2'b11
    } modo_e;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_STEP  = 3;

endpackage : modo_counter_param_pkg

// File: rtl/modo_counter_param_next_unit.sv
// Combinational next-value and wrap/clamp flag generator for modo_counter_param.
// Honours MODO_SAT_EN: when defined, up modes clamp at MAX and down clamps at 0.
module modo_next_unit
    import modo_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = DEFAULT_STEP
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] sum_step;
    logic [WIDTH:0] sum_one;
    logic [WIDTH:0] diff_one;

    // Bit WIDTH of each result is the carry (or borrow) that defines a wrap.
    assign q_ext    = {1'b0, q};
    assign sum_step = q_ext + STEP_EXT;
    assign sum_one  = q_ext + ONE_EXT;
    assign diff_one = q_ext - ONE_EXT;

    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        case (modo)
            MODO_UP_STEP: begin
                wrap = sum_step[WIDTH];
`ifdef MODO_SAT_EN
                q_next = sum_step[WIDTH] ? '1 : sum_step[WIDTH-1:0];
`else
                q_next = sum_step[WIDTH-1:0];
`endif
            end
            MODO_DOWN: begin
                wrap = diff_one[WIDTH];
`ifdef MODO_SAT_EN
                q_next = diff_one[WIDTH] ? '0 : diff_one[WIDTH-1:0];
`else
                q_next = diff_one[WIDTH-1:0];
`endif
            end
            MODO_UP: begin
                wrap = sum_one[WIDTH];
`ifdef MODO_SAT_EN
                q_next = sum_one[WIDTH] ? '1 : sum_one[WIDTH-1:0];
`else
                q_next = sum_one[WIDTH-1:0];
`endif
            end
            MODO_LOAD: begin
                q_next = d;
                wrap   = 1'b0;
            end
            default: begin
                q_next = q;
                wrap   = 1'b0;
            end
        endcase
    end

endmodule : modo_next_unit

// File: rtl/modo_counter_param.sv
// WIDTH-bit four-mode counter with registered one-cycle rco flag.
// Saturating variant selected at compile time with MODO_SAT_EN.
module modo_counter_param
    import modo_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             rco_q;
    logic             rco_d;

    modo_next_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .q      (q_q),
        .modo   (modo),
        .d      (d),
        .q_next (q_d),
        .wrap   (rco_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else if (!enable) begin
            q_q   <= q_q;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign q   = q_q;
    assign rco = rco_q;

endmodule : modo_counter_param

// File: tb/tb_modo_counter_param.sv
// Directed self-checking bench for modo_counter_param: default 4/3 instance and an 8/5 instance.
// Expected values follow the wrapping build, or the clamping build when MODO_SAT_EN is defined.
module tb_modo_counter_param;
    import modo_counter_param_pkg::*;

    logic       clk;
    logic       rst4, en4, rco4;
    logic [1:0] modo4;
    logic [3:0] d4, q4;
    logic       rst8, en8, rco8;
    logic [1:0] modo8;
    logic [7:0] d8, q8;

    int checks   = 0;
    int failures = 0;

    modo_counter_param #(.WIDTH(4), .STEP(3)) dut4 (
        .clk(clk), .rst(rst4), .enable(en4), .modo(modo4), .d(d4), .q(q4), .rco(rco4)
    );

    modo_counter_param #(.WIDTH(8), .STEP(5)) dut8 (
        .clk(clk), .rst(rst8), .enable(en8), .modo(modo8), .d(d8), .q(q8), .rco(rco8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step4(input logic r, input logic e, input logic [1:0] m, input logic [3:0] dv);
        rst4 = r; en4 = e; modo4 = m; d4 = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic r, input logic e, input logic [1:0] m, input logic [7:0] dv);
        rst8 = r; en8 = e; modo8 = m; d8 = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst4 = 1'b1; en4 = 1'b0; modo4 = 2'b00; d4 = '0;
        rst8 = 1'b1; en8 = 1'b0; modo8 = 2'b00; d8 = '0;

        // Reset from q=9 while enabled in mode 00, then one free edge
        step4(1'b0, 1'b1, MODO_LOAD, 4'd9);
        check("pre_reset_load_q", q4, 9);
        step4(1'b1, 1'b1, MODO_UP_STEP, 4'd0);
        check("reset_q", q4, 0);
        check("reset_rco", rco4, 0);
        step4(1'b0, 1'b1, MODO_UP_STEP, 4'd0);
        check("post_reset_q", q4, 3);
        check("post_reset_rco", rco4, 0);

        // Mode 00 wrap from 14
        step4(1'b0, 1'b1, MODO_LOAD, 4'd14);
        check("load14_q", q4, 14);
        check("load14_rco", rco4, 0);
        step4(1'b0, 1'b1, MODO_UP_STEP, 4'd0);
`ifdef MODO_SAT_EN
        check("m00_wrap_q", q4, 15);
        check("m00_wrap_rco", rco4, 1);
        step4(1'b0, 1'b1, MODO_UP_STEP, 4'd0);
        check("m00_next_q", q4, 15);
        check("m00_next_rco", rco4, 1);
`else
        check("m00_wrap_q", q4, 1);
        check("m00_wrap_rco", rco4, 1);
        step4(1'b0, 1'b1, MODO_UP_STEP, 4'd0);
        check("m00_next_q", q4, 4);
        check("m00_next_rco", rco4, 0);
`endif

        // Mode 01 borrow from 1
        step4(1'b0, 1'b1, MODO_LOAD, 4'd1);
        check("load1_q", q4, 1);
        step4(1'b0, 1'b1, MODO_DOWN, 4'd0);
        check("m01_e1_q", q4, 0);
        check("m01_e1_rco", rco4, 0);
        step4(1'b0, 1'b1, MODO_DOWN, 4'd0);
`ifdef MODO_SAT_EN
        check("m01_e2_q", q4, 0);
        check("m01_e2_rco", rco4, 1);
        step4(1'b0, 1'b1, MODO_DOWN, 4'd0);
        check("m01_e3_q", q4, 0);
        check("m01_e3_rco", rco4, 1);
`else
        check("m01_e2_q", q4, 15);
        check("m01_e2_rco", rco4, 1);
        step4(1'b0, 1'b1, MODO_DOWN, 4'd0);
        check("m01_e3_q", q4, 14);
        check("m01_e3_rco", rco4, 0);
`endif

        // Mode 10 rollover then enable hold
        step4(1'b0, 1'b1, MODO_LOAD, 4'd15);
        check("load15_q", q4, 15);
        step4(1'b0, 1'b1, MODO_UP, 4'd0);
`ifdef MODO_SAT_EN
        check("m10_roll_q", q4, 15);
        check("m10_roll_rco", rco4, 1);
        step4(1'b0, 1'b0, MODO_UP, 4'd0);
        check("hold1_q", q4, 15);
        check("hold1_rco", rco4, 0);
        step4(1'b0, 1'b0, MODO_LOAD, 4'd7);
        check("hold2_q", q4, 15);
        check("hold2_rco", rco4, 0);
`else
        check("m10_roll_q", q4, 0);
        check("m10_roll_rco", rco4, 1);
        step4(1'b0, 1'b0, MODO_UP, 4'd0);
        check("hold1_q", q4, 0);
        check("hold1_rco", rco4, 0);
        step4(1'b0, 1'b0, MODO_LOAD, 4'd7);
        check("hold2_q", q4, 0);
        check("hold2_rco", rco4, 0);
`endif

        // Plain up count and a mode change on the very next edge
        step4(1'b0, 1'b1, MODO_LOAD, 4'd5);
        step4(1'b0, 1'b1, MODO_UP, 4'd0);
        check("m10_inc_q", q4, 6);
        check("m10_inc_rco", rco4, 0);
        step4(1'b0, 1'b1, MODO_DOWN, 4'd0);
        check("mode_switch_q", q4, 5);

        // Reset mid-load, and reset discarding a pending wrap
        step4(1'b1, 1'b1, MODO_LOAD, 4'd10);
        check("rst_midload_q", q4, 0);
        check("rst_midload_rco", rco4, 0);
        step4(1'b0, 1'b1, MODO_LOAD, 4'd15);
        step4(1'b1, 1'b1, MODO_UP, 4'd0);
        check("rst_midwrap_q", q4, 0);
        check("rst_midwrap_rco", rco4, 0);

        // Width 8 / step 5 instance
        step8(1'b1, 1'b1, MODO_LOAD, 8'd77);
        check("w8_reset_q", q8, 0);
        step8(1'b0, 1'b1, MODO_LOAD, 8'd253);
        check("w8_load_q", q8, 253);
        step8(1'b0, 1'b1, MODO_UP_STEP, 8'd0);
`ifdef MODO_SAT_EN
        check("w8_e1_q", q8, 255);
        check("w8_e1_rco", rco8, 1);
        step8(1'b0, 1'b1, MODO_UP_STEP, 8'd0);
        check("w8_e2_q", q8, 255);
        check("w8_e2_rco", rco8, 1);
        step8(1'b0, 1'b1, MODO_UP, 8'd0);
        check("w8_up_q", q8, 255);
        check("w8_up_rco", rco8, 1);
`else
        check("w8_e1_q", q8, 2);
        check("w8_e1_rco", rco8, 1);
        step8(1'b0, 1'b1, MODO_UP_STEP, 8'd0);
        check("w8_e2_q", q8, 7);
        check("w8_e2_rco", rco8, 0);
        step8(1'b0, 1'b1, MODO_LOAD, 8'd255);
        step8(1'b0, 1'b1, MODO_UP, 8'd0);
        check("w8_up_q", q8, 0);
        check("w8_up_rco", rco8, 1);
`endif
        step8(1'b0, 1'b1, MODO_LOAD, 8'd128);
        check("w8_load128_rco", rco8, 0);
        step8(1'b0, 1'b1, MODO_DOWN, 8'd0);
        check("w8_down_q", q8, 127);
        check("w8_down_rco", rco8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_modo_counter_param
